// File: rtl/adder_pkg.sv
// ----------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the bit-serial adder family.
//   state_t              : control FSM encoding (IDLE / RUN / DONE)
//   ADDER_WIDTH_DEFAULT  : default operand/result width in bits
// ----------------------------------------------------------------------------
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int ADDER_WIDTH_DEFAULT = 8;

endpackage : adder_pkg

// File: rtl/fulladder.sv
// ----------------------------------------------------------------------------
// fulladder
// One-bit full-adder cell, purely combinational.
//   a, b, c : addend bits and carry-in
//   s       : sum bit
//   cout    : carry-out
// ----------------------------------------------------------------------------
module fulladder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ c;
    assign cout = (a & b) | (a & c) | (b & c);

endmodule : fulladder

// File: rtl/serial_adder.sv
// ----------------------------------------------------------------------------
// serial_adder
// Bit-serial adder computing a + b + cin over WIDTH cycles with a single
// full-adder cell and a registered carry. Operands are captured on an accepted
// start (in IDLE or DONE) and consumed LSB first; sum bits enter at the MSB of
// the result register, so after WIDTH shifts the result is aligned.
//
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : begin an addition (ignored while busy)
//   a, b, cin  : operands and carry-in, captured on an accepted start
//   busy       : addition in progress
//   done       : one-cycle pulse, result complete
//   sum, cout  : result and final carry, held until the next accepted start
// ----------------------------------------------------------------------------
module serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int                CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic               carry;
    logic [CNT_W-1:0]   cnt;

    logic               fa_s;
    logic               fa_cout;
    logic [WIDTH-1:0]   sum_shift;

    fulladder u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .c    (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // Result register shifted right with the new sum bit entering at the MSB.
    // Written as shift-then-overwrite so WIDTH=1 needs no special slicing.
    // NOTE: every always_comb output gets a full default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        sum_shift            = sum >> 1;
        sum_shift[WIDTH-1]   = fa_s;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    // NOTE: all state, including the operand/result shift registers, is reset;
    // they are only a few flops wide and a partial result must never survive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        sum   <= '0;
                        cout  <= 1'b0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end

                RUN: begin
                    // start is deliberately not looked at here.
                    sum   <= sum_shift;
                    carry <= fa_cout;
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST_CNT) begin
                        cout  <= fa_cout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : serial_adder
